// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         SAT_MAX_W = 32;

    // All-ones value of a w-bit counter, used as the saturation ceiling.
    function automatic logic [SAT_MAX_W-1:0] sat_ones(input int w);
        if (w >= SAT_MAX_W)
            sat_ones = '1;
        else
            sat_ones = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the load in EX and the sources of the ID instruction.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       lu_hazard
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match  = (ex_rt == id_rs);
        rt_match  = id_uses_rt && (ex_rt == id_rt);
        lu_hazard = ex_memread && (ex_rt != REG_ZERO) && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: prioritised Mealy control outputs, dmem wait FSM,
// wait watchdog and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             id_jump,
    input  logic             mem_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic             wait_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int               WC_W    = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(TIMEOUT);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_ones(CNT_W));

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu_hazard;
    logic             wait_cond;

    hazard_detect u_hazard_detect (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .lu_hazard  (lu_hazard)
    );

    assign wait_cond = dmem_req && !dmem_ready;

    // active_q holds the reset-style outputs until the first edge after rst_n rises.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;
        if (!rst_n || !active_q) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (wait_cond) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end else if (lu_hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        active_d    = 1'b1;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (wait_cond)
                    state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (wait_cnt_q != WC_MAX)
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                if (wait_cnt_q >= WC_LAST)
                    timeout_d = 1'b1;
                if (!wait_cond)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        if (active_q && !pc_write && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (active_q && (ifid_flush || idex_flush || exmem_flush) && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            active_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            active_q    <= active_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign wait_timeout = timeout_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven scoreboard bench for pipeline_hazard_ctrl (small counters, short watchdog).
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 3;
    localparam int CMAX    = 15;

    // Expected output order: pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, wait_timeout
    localparam logic [6:0] E_NORM = 7'b1100000;
    localparam logic [6:0] E_LU   = 7'b0001000;
    localparam logic [6:0] E_BR   = 7'b1111100;
    localparam logic [6:0] E_JMP  = 7'b1110000;
    localparam logic [6:0] E_HOLD = 7'b0000010;
    localparam logic [6:0] E_RST  = 7'b0011100;
    localparam logic [6:0] E_TO   = 7'b0000001;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       jump;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
    logic             id_uses_rt = 1'b0, ex_memread = 1'b0, id_jump = 1'b0;
    logic             mem_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, wait_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_stall  = 0;
    int   m_flush  = 0;
    vec_t sb_q[$];
    vec_t tbl[15];
    string onames[7] = '{"pc_write", "ifid_write", "ifid_flush", "idex_flush",
                         "exmem_flush", "pipe_hold", "wait_timeout"};

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_memread       (ex_memread),
        .ex_rt            (ex_rt),
        .id_jump          (id_jump),
        .mem_branch_taken (mem_branch_taken),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .pipe_hold        (pipe_hold),
        .wait_timeout     (wait_timeout),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                                input logic mr, input logic [4:0] ert, input logic jmp,
                                input logic br, input logic req, input logic rdy,
                                input logic [6:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = uses; v.memread = mr; v.ex_rt = ert;
        v.jump = jmp; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
        ex_memread = v.memread; ex_rt = v.ex_rt; id_jump = v.jump;
        mem_branch_taken = v.br; dmem_req = v.req; dmem_ready = v.rdy;
        sb_q.push_back(v);
    endtask

    // Compares the combinational outputs of the current cycle and the counters accumulated so far.
    task automatic checkOutput(input string tag);
        vec_t       v;
        logic [6:0] act;
        #2;
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 1, 0);
            return;
        end
        v   = sb_q.pop_front();
        act = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, wait_timeout};
        for (int i = 0; i < 7; i++)
            chk($sformatf("%s %s", tag, onames[i]), int'(act[6-i]), int'(v.exp[6-i]));
        chk({tag, " stall_cnt"}, int'(stall_cnt), m_stall);
        chk({tag, " flush_cnt"}, int'(flush_cnt), m_flush);
        if (!v.exp[6] && m_stall < CMAX) m_stall++;
        if ((v.exp[4] || v.exp[3] || v.exp[2]) && m_flush < CMAX) m_flush++;
    endtask

    task automatic step(input string tag, input vec_t v);
        applyStimulus(v);
        checkOutput(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk({tag, " state"}, int'(dut.state_q), int'(RUN));
        chk({tag, " outs"}, int'({pc_write, ifid_write, ifid_flush, idex_flush,
                                  exmem_flush, pipe_hold, wait_timeout}), int'(E_RST));
        chk({tag, " stall_cnt"}, int'(stall_cnt), 0);
        chk({tag, " flush_cnt"}, int'(flush_cnt), 0);
        m_stall = 0;
        m_flush = 0;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_rt = '0;
        id_jump = 1'b0; mem_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM);
        tbl[1]  = mk(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, E_LU);
        tbl[2]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM);
        tbl[3]  = mk(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, E_LU);
        tbl[4]  = mk(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM);
        tbl[5]  = mk(5'd8, 5'd2, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM);
        tbl[6]  = mk(5'd4, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_JMP);
        tbl[7]  = mk(5'd4, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, E_BR);
        tbl[8]  = mk(5'd7, 5'd5, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, E_BR);
        tbl[9]  = mk(5'd7, 5'd5, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_JMP);
        tbl[10] = mk(5'd6, 5'd5, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, E_LU);
        tbl[11] = mk(5'd6, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM);
        tbl[12] = mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_HOLD);
        tbl[13] = mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, E_BR);
        tbl[14] = mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM);

        do_reset("reset0");
        for (int i = 0; i < 15; i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // Branch held behind a dmem wait; the watchdog trips on the third MEM_WAIT cycle.
        do_reset("reset1");
        for (int i = 0; i < 4; i++)
            step($sformatf("brwait%0d", i), mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_HOLD));
        step("brwait_ready", mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, E_BR | E_TO));
        step("brwait_after", mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM | E_TO));

        do_reset("reset2");
        for (int i = 0; i < 5; i++)
            step($sformatf("tmo%0d", i), mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                                            (i == 4) ? (E_HOLD | E_TO) : E_HOLD));
        step("tmo_ready", mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_NORM | E_TO));
        step("tmo_idle",  mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM | E_TO));
        step("midwait0",  mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_HOLD | E_TO));
        step("midwait1",  mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_HOLD | E_TO));
        do_reset("reset_midwait");
        step("post_reset", mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM));

        for (int i = 0; i < 18; i++)
            step($sformatf("sat%0d", i), mk(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, E_LU));
        @(negedge clk);
        #2;
        chk("sat stall_cnt", int'(stall_cnt), CMAX);
        chk("sat flush_cnt", int'(flush_cnt), CMAX);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
